readbuf_ctrl: RTL and testbench

Parametrised read-side controller for the multi-line packet buffer. It tracks up to 2^LINES_W completed lines written by the write side and issues reads to the synchronous buffer RAM. It streams each line out as one AXI-Stream packet through an internal 2-entry output buffer, so that tready back-pressure never drops or duplicates a word. When a line has been sent, it is returned to the write side.

---
 rtl/readbuf_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_readbuf_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/readbuf_ctrl.sv
// Read-side controller for the multi-line packet buffer: streams each completed line as one AXI-Stream packet.
// Optional macro READBUF_STALL_CNT_EN adds a saturating tvalid-without-tready cycle counter (stall_cnt).
module readbuf_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 11,
  parameter int LINES_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_line_done,
  input  logic [ADDR_W-1:0]          wr_last_idx,
  output logic                       rd_en,
  output logic [LINES_W+ADDR_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0]          rd_data,
  output logic [DATA_W-1:0]          tdata,
  output logic                       tvalid,
  output logic                       tlast,
  input  logic                       tready,
  output logic                       line_free,
  output logic [LINES_W:0]           lines_pending,
  output logic                       overflow_err
`ifdef READBUF_STALL_CNT_EN
  ,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int DEPTH = 1 << LINES_W;
  localparam logic [LINES_W:0] FULL = {1'b1, {LINES_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, READ, FLUSH} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   len_q [DEPTH];
  logic [ADDR_W-1:0]   len_d [DEPTH];
  logic [LINES_W-1:0]  wr_ptr_q, wr_ptr_d, rd_line_q, rd_line_d;
  logic [ADDR_W-1:0]   rd_word_q, rd_word_d, last_idx_q, last_idx_d;
  logic [LINES_W:0]    pend_q, pend_d;
  logic                ovf_q, ovf_d;
  logic                inflight_q, inflight_d, tag_q, tag_d;
  logic [DATA_W-1:0]   buf_data_q [2];
  logic [DATA_W-1:0]   buf_data_d [2];
  logic                buf_last_q [2];
  logic                buf_last_d [2];
  logic                head_q, head_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                push, pop, hs_last, credit_ok, is_last_word;
  logic [1:0]          occ_next;
`ifdef READBUF_STALL_CNT_EN
  logic [15:0]         stall_q, stall_d;
`endif

  // The FIFO read pointer is rd_line itself: lines are consumed strictly in order.
  assign tvalid        = (cnt_q != 2'd0);
  assign tdata         = buf_data_q[head_q];
  assign tlast         = tvalid & buf_last_q[head_q];
  assign pop           = tvalid & tready;
  assign hs_last       = pop & tlast;
  assign line_free     = (state_q == FLUSH) & hs_last;
  assign push          = wr_line_done & (pend_q < FULL);
  assign lines_pending = pend_q;
  assign overflow_err  = ovf_q;
  assign is_last_word  = (rd_word_q == last_idx_q);

  // Occupancy after this cycle's capture and pop; a new read is safe only below 2.
  assign occ_next  = cnt_q + 2'(inflight_q) - 2'(pop);
  assign credit_ok = (occ_next < 2'd2);
  assign rd_en     = (state_q == READ) & credit_ok;
  assign rd_addr   = {rd_line_q, rd_word_q};
`ifdef READBUF_STALL_CNT_EN
  assign stall_cnt = stall_q;
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_ptr_d   = wr_ptr_q;
    rd_line_d  = rd_line_q;
    rd_word_d  = rd_word_q;
    last_idx_d = last_idx_q;
    pend_d     = pend_q;
    ovf_d      = ovf_q | (wr_line_done & ~push);
    inflight_d = rd_en;
    tag_d      = rd_en & is_last_word;
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    head_d     = head_q;
    cnt_d      = occ_next;
`ifdef READBUF_STALL_CNT_EN
    stall_d    = stall_q;
    if (tvalid && !tready && stall_q != 16'hFFFF) stall_d = stall_q + 16'(1);
`endif

    if (push) begin
      len_d[wr_ptr_q] = wr_last_idx;
      wr_ptr_d        = wr_ptr_q + LINES_W'(1);
    end

    case ({push, line_free})
      2'b10:   pend_d = pend_q + (LINES_W+1)'(1);
      2'b01:   pend_d = pend_q - (LINES_W+1)'(1);
      default: pend_d = pend_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          state_d    = READ;
          rd_word_d  = '0;
          last_idx_d = len_q[rd_line_q];
        end
      end
      READ: begin
        if (rd_en) begin
          if (is_last_word) begin
            state_d   = FLUSH;
            rd_word_d = '0;
          end else begin
            rd_word_d = rd_word_q + ADDR_W'(1);
          end
        end
      end
      FLUSH: begin
        if (hs_last) begin
          state_d   = IDLE;
          rd_line_d = rd_line_q + LINES_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (inflight_q) begin
      buf_data_d[head_q ^ cnt_q[0]] = rd_data;
      buf_last_d[head_q ^ cnt_q[0]] = tag_q;
    end
    if (pop) head_d = ~head_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      for (int i = 0; i < DEPTH; i++) len_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_line_q  <= '0;
      rd_word_q  <= '0;
      last_idx_q <= '0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
      inflight_q <= 1'b0;
      tag_q      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
      end
      head_q     <= 1'b0;
      cnt_q      <= 2'd0;
`ifdef READBUF_STALL_CNT_EN
      stall_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_line_q  <= rd_line_d;
      rd_word_q  <= rd_word_d;
      last_idx_q <= last_idx_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      buf_data_q <= buf_data_d;
      buf_last_q <= buf_last_d;
      head_q     <= head_d;
      cnt_q      <= cnt_d;
`ifdef READBUF_STALL_CNT_EN
      stall_q    <= stall_d;
`endif
    end
  end

endmodule

// File: tb/tb_readbuf_ctrl.sv
// Bench for readbuf_ctrl: cycle table for a single line, directed corner sequences, randomized traffic
// against a packet-level reference model (expected address and beat queues).
module tb_readbuf_ctrl;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 11;
  localparam int LINES_W = 2;
  localparam int RA_W    = LINES_W + ADDR_W;
  localparam int NLINES  = 1 << LINES_W;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                wr_line_done = 1'b0;
  logic [ADDR_W-1:0]   wr_last_idx = '0;
  logic                rd_en;
  logic [RA_W-1:0]     rd_addr;
  logic [DATA_W-1:0]   rd_data = '0;
  logic [DATA_W-1:0]   tdata;
  logic                tvalid, tlast;
  logic                tready = 1'b0;
  logic                line_free;
  logic [LINES_W:0]    lines_pending;
  logic                overflow_err;
`ifdef READBUF_STALL_CNT_EN
  logic [15:0]         stall_cnt;
`endif

  readbuf_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINES_W(LINES_W)) dut (
    .clk(clk), .rst(rst), .wr_line_done(wr_line_done), .wr_last_idx(wr_last_idx),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tdata(tdata), .tvalid(tvalid), .tlast(tlast), .tready(tready),
    .line_free(line_free), .lines_pending(lines_pending), .overflow_err(overflow_err)
`ifdef READBUF_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // synchronous buffer RAM, one cycle read latency
  logic [DATA_W-1:0] ram [1 << RA_W];
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // scoreboard / reference model
  logic [DATA_W:0]   exp_q [$];
  logic [RA_W-1:0]   addr_q [$];
  int                pend_m, acc_m, issued, accepted, beats, pk;
  bit                ovf_m, hold_v, mon_en;
  logic [DATA_W-1:0] hold_d;
  logic              hold_l, m_pop, m_free, m_push;
  logic [DATA_W:0]   m_e;
  logic [RA_W-1:0]   m_a;

  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_outputs", 32'({rd_en, rd_addr, tdata, tvalid, tlast, line_free, lines_pending, overflow_err}), 32'd0);
`ifdef READBUF_STALL_CNT_EN
      chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      exp_q.delete(); addr_q.delete();
      pend_m = 0; acc_m = 0; issued = 0; accepted = 0; ovf_m = 0; hold_v = 0;
    end else if (mon_en) begin
      chk("lines_pending", 32'(lines_pending), 32'(pend_m));
      chk("overflow_err", 32'(overflow_err), 32'(ovf_m));
      if (int'(lines_pending) > pk) pk = int'(lines_pending);
      if (hold_v) chk("hold_stable", 32'({tvalid, tlast, tdata}), 32'({1'b1, hold_l, hold_d}));
      m_pop = tvalid && tready;
      if (rd_en) begin
        chk("credit", 32'((issued - accepted - int'(m_pop)) < 2), 32'd1);
        if (addr_q.size() == 0) chk("rd_addr_extra", 32'(addr_q.size()), 32'd1);
        else chk("rd_addr", 32'(rd_addr), 32'(addr_q.pop_front()));
        issued++;
      end
      m_free = 1'b0;
      if (m_pop) begin
        if (exp_q.size() == 0) chk("beat_extra", 32'(exp_q.size()), 32'd1);
        else begin
          m_e = exp_q.pop_front();
          chk("beat", 32'({tlast, tdata}), 32'(m_e));
          m_free = m_e[DATA_W];
        end
        accepted++; beats++;
      end
      chk("line_free", 32'(line_free), 32'(m_free));
      hold_v = tvalid && !tready; hold_d = tdata; hold_l = tlast;
      m_push = wr_line_done && (pend_m < NLINES);
      if (wr_line_done && !m_push) ovf_m = 1'b1;
      if (m_push) begin
        for (int w = 0; w <= int'(wr_last_idx); w++) begin
          m_a = RA_W'((acc_m % NLINES) * (1 << ADDR_W) + w);
          addr_q.push_back(m_a);
          exp_q.push_back({(w == int'(wr_last_idx)), ram[m_a]});
        end
        acc_m++;
      end
      pend_m = pend_m + int'(m_push) - int'(m_free);
    end
  end

  // driver tasks
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; wr_line_done = 1'b0; tready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic push_line(input int idx);
    @(posedge clk); #1;
    wr_line_done = 1'b1; wr_last_idx = ADDR_W'(idx);
    @(posedge clk); #1;
    wr_line_done = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    tready = 1'b1;
    @(posedge clk); #2;
    while (k < 500 && !(exp_q.size() == 0 && pend_m == 0 && !tvalid)) begin
      @(posedge clk); #2;
      k++;
    end
    chk(name, 32'(k < 500), 32'd1);
  endtask

  task automatic wait_tvalid(input string name);
    int k;
    k = 0;
    @(posedge clk); #2;
    while (k < 100 && !tvalid) begin
      @(posedge clk); #2;
      k++;
    end
    chk(name, 32'(tvalid), 32'd1);
  endtask

  typedef struct {
    logic              wld;
    logic [ADDR_W-1:0] lidx;
    logic              trdy;
    logic              e_rden;
    logic [RA_W-1:0]   e_addr;
    logic              e_tvalid;
    logic [DATA_W-1:0] e_tdata;
    logic              e_tlast;
    logic              e_free;
    logic [LINES_W:0]  e_pend;
  } vec_t;

  vec_t tbl [9];
  logic [RA_W-1:0]   t_addr;
  logic [DATA_W-1:0] t_data;
  logic [1:0]        t_line;
  bit                bp_pat [8];
  int                b2b_idx [4];
  int                k;

  initial begin
    for (int i = 0; i < (1 << RA_W); i++) ram[i] = DATA_W'($urandom);
    for (int i = 0; i < 4; i++) ram[i] = DATA_W'(8'h11 + i);

    // single 4-word line, tready held high, cycle by cycle
    tbl[0] = '{1, 3, 1, 0, 0, 0, 8'h00, 0, 0, 0};
    tbl[1] = '{0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 1};
    tbl[2] = '{0, 0, 1, 1, 0, 0, 8'h00, 0, 0, 1};
    tbl[3] = '{0, 0, 1, 1, 1, 0, 8'h00, 0, 0, 1};
    tbl[4] = '{0, 0, 1, 1, 2, 1, 8'h11, 0, 0, 1};
    tbl[5] = '{0, 0, 1, 1, 3, 1, 8'h12, 0, 0, 1};
    tbl[6] = '{0, 0, 1, 0, 0, 1, 8'h13, 0, 0, 1};
    tbl[7] = '{0, 0, 1, 0, 0, 1, 8'h14, 1, 1, 1};
    tbl[8] = '{0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0};
    bp_pat = '{1, 0, 0, 1, 0, 1, 1, 1};
    b2b_idx = '{0, 2, 5, 1};

    mon_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      wr_line_done = tbl[i].wld; wr_last_idx = tbl[i].lidx; tready = tbl[i].trdy;
      @(negedge clk);
      t_addr = tbl[i].e_rden ? rd_addr : '0;
      t_data = tbl[i].e_tvalid ? tdata : '0;
      chk($sformatf("table_row%0d", i),
          32'({rd_en, t_addr, tvalid, t_data, tlast, line_free, lines_pending}),
          32'({tbl[i].e_rden, tbl[i].e_addr, tbl[i].e_tvalid, tbl[i].e_tdata,
               tbl[i].e_tlast, tbl[i].e_free, tbl[i].e_pend}));
    end

    // back-pressure on an 8-word line
    do_reset();
    mon_en = 1'b1; beats = 0;
    tready = 1'b1;
    push_line(7);
    wait_tvalid("bp_first_valid");
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1 tready = bp_pat[i];
    end
    drain("bp_drain");
    chk("bp_beats", 32'(beats), 32'd8);
`ifdef READBUF_STALL_CNT_EN
    chk("bp_stall_cnt", 32'(stall_cnt), 32'd3);
`endif

    // four lines back to back, lines 0..3
    do_reset();
    pk = 0; tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      wr_line_done = 1'b1; wr_last_idx = ADDR_W'(b2b_idx[i]);
    end
    @(posedge clk); #1 wr_line_done = 1'b0;
    drain("b2b_drain");
    chk("b2b_peak", 32'(pk), 32'd4);
    chk("b2b_no_overflow", 32'(overflow_err), 32'd0);

    // overflow: five pushes while stalled, then a line after wrap
    tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      wr_line_done = 1'b1; wr_last_idx = ADDR_W'($urandom_range(0, 3));
    end
    @(posedge clk); #1 wr_line_done = 1'b0;
    @(posedge clk); #2;
    chk("ovf_flag", 32'(overflow_err), 32'd1);
    chk("ovf_pending", 32'(lines_pending), 32'd4);
    drain("ovf_drain");
    push_line(2);
    k = 0;
    @(posedge clk); #2;
    while (k < 50 && !rd_en) begin
      @(posedge clk); #2;
      k++;
    end
    t_line = rd_addr[RA_W-1:ADDR_W];
    chk("wrap_line", 32'({rd_en, t_line}), 32'({1'b1, 2'd0}));
    drain("wrap_drain");

    // wr_line_done coincident with the tlast handshake
    tready = 1'b0;
    push_line(0);
    wait_tvalid("sim_valid");
    @(posedge clk); #1;
    wr_line_done = 1'b1; wr_last_idx = ADDR_W'(1); tready = 1'b1;
    @(negedge clk); #1;
    chk("sim_line_free", 32'(line_free), 32'd1);
    chk("sim_pending_before", 32'(lines_pending), 32'd1);
    @(posedge clk); #1 wr_line_done = 1'b0;
    @(negedge clk); #1;
    chk("sim_pending_after", 32'(lines_pending), 32'd1);
    drain("sim_drain");

    // reset during the third beat of a 6-word line
    beats = 0; tready = 1'b1;
    push_line(5);
    k = 0;
    @(negedge clk); #1;
    while (k < 100 && beats < 2) begin
      @(negedge clk); #1;
      k++;
    end
    chk("rstmid_two_beats", 32'(beats), 32'd2);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("rstmid_outputs", 32'({tvalid, tlast, rd_en, line_free, lines_pending}), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    beats = 0;
    push_line(5);
    drain("rstmid_drain");
    chk("rstmid_beats", 32'(beats), 32'd6);

    // randomized traffic
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk); #1;
      tready       = ($urandom_range(0, 3) != 0);
      wr_line_done = ($urandom_range(0, 11) == 0);
      wr_last_idx  = ADDR_W'($urandom_range(0, 7));
    end
    @(posedge clk); #1 wr_line_done = 1'b0;
    drain("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
